load_store_unit: RTL and testbench

// - Memory-stage adapter between the pipeline and the word-only data memory (dmem: WE/A/WD/RD,
//   256x32, combinational read, posedge write).
// - Adds byte/halfword loads (sign/zero extend) and stores. Sub-word stores use a 2-cycle

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage adapter adding byte/half access to a word-only dmem
//
// Purpose:
//   Sits between the pipeline memory stage and a word-only data memory
//   (combinational read, posedge write). Adds byte and halfword loads with
//   sign/zero extension and sub-word stores via a two-cycle read-modify-write.
//   Misaligned, reserved-size and out-of-range requests complete with resp_err.
//
// Configuration macro:
//   LSU_MISALIGN_CHK_EN  defined   : size 11, misaligned half/word raise resp_err
//                        undefined : address is forced to the natural alignment
//                                    of the size, size 11 acts as word; only the
//                                    out-of-range check raises resp_err
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (accept = valid & ready)
//   req_we, req_size      1=store; 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned          loads: 1 zero-extend, 0 sign-extend
//   req_addr, req_wdata   byte address, right-justified store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  load result (0 for stores/errors), error flag
//   mem_we, mem_addr      dmem write enable and word-aligned byte address
//   mem_wd, mem_rd        dmem write data and combinational read data

module load_store_unit #(
    parameter int MEM_AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [31:0] rmw_data;
    logic [31:0] rmw_addr;

    logic [1:0]  eff_size;
    logic [1:0]  eff_off;
    logic        range_err;
    logic        align_err;
    logic        req_err;
    logic        accept;
    logic        is_sub_st;
    logic [31:0] word_addr;
    logic [4:0]  lane_shift;
    logic [15:0] rd_lane;
    logic [31:0] load_data;
    logic [31:0] lane_bits;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic        mem_we_c;

    // Request decode: effective size/offset, error detection, lane steering.
    always_comb begin
        range_err = (req_addr >> (MEM_AW + 2)) != 32'd0;
`ifdef LSU_MISALIGN_CHK_EN
        eff_size  = req_size;
        eff_off   = req_addr[1:0];
        align_err = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        eff_size  = (req_size == 2'b11) ? 2'b10 : req_size;
        case (eff_size)
            2'b00:   eff_off = req_addr[1:0];
            2'b01:   eff_off = {req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
        align_err = 1'b0;
`endif
        req_err    = range_err | align_err;
        word_addr  = {req_addr[31:2], 2'b00};
        lane_shift = {eff_off, 3'b000};
        rd_lane    = 16'(mem_rd >> lane_shift);

        case (eff_size)
            2'b00:   load_data = req_unsigned ? {24'd0, rd_lane[7:0]}
                                              : {{24{rd_lane[7]}}, rd_lane[7:0]};
            2'b01:   load_data = req_unsigned ? {16'd0, rd_lane}
                                              : {{16{rd_lane[15]}}, rd_lane};
            default: load_data = mem_rd;
        endcase

        // Store data is masked to its lane width so stray upper bits cannot
        // corrupt neighbouring bytes of the merged word.
        lane_bits = (eff_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        lane_mask = lane_bits << lane_shift;
        merged    = (mem_rd & ~lane_mask) | ((req_wdata & lane_bits) << lane_shift);
    end

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign is_sub_st = req_we & (eff_size != 2'b10);

    // Next state and dmem drive; address/data are zero when nothing is happening.
    always_comb begin
        state_nx = state;
        mem_we_c = 1'b0;
        mem_addr = 32'd0;
        mem_wd   = 32'd0;
        case (state)
            IDLE: begin
                if (accept && !req_err) begin
                    mem_addr = word_addr;
                    if (is_sub_st) begin
                        state_nx = RMW_WR;
                    end else if (req_we) begin
                        mem_we_c = 1'b1;
                        mem_wd   = req_wdata;
                    end
                end
            end
            RMW_WR: begin
                mem_we_c = 1'b1;
                mem_addr = rmw_addr;
                mem_wd   = rmw_data;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A write must never reach dmem while reset is asserted.
    assign mem_we = mem_we_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            rmw_data   <= 32'd0;
            rmw_addr   <= 32'd0;
        end else begin
            state      <= state_nx;
            // Sub-word stores respond after the write cycle instead of at accept.
            resp_valid <= (accept && (req_err || !is_sub_st)) || (state == RMW_WR);
            resp_err   <= accept && req_err;
            resp_rdata <= (accept && !req_err && !req_we) ? load_data : 32'd0;
            if (accept && !req_err && is_sub_st) begin
                rmw_data <= merged;
                rmw_addr <= word_addr;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a dmem model
module tb_load_store_unit;

`ifdef LSU_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] dmem [256];

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.MEM_AW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[9:2]] <= mem_wd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic we, logic [1:0] sz, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rd, logic exp_err,
                                int exp_lat, logic exp_rdy);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_rdy = exp_rdy;
        return v;
    endfunction

    // Issue one request from an idle unit and wait (bounded) for its response.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rdy_acc, output logic rdy_after);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        #1;
        rdy_acc = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rdy_after = req_ready;
        lat = 1;
        while (!resp_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        rdy_acc;
        logic        rdy_after;
        logic [31:0] word10;
        int          seen;

        for (int i = 0; i < 256; i++) dmem[i] = 32'd0;

        vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h11,  32'h5A,       32'h0,        0, 2, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEAD5AEF, 0, 1, 1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0, 1, 1));
        vecs.push_back(mk(0, 2'b00, 1, 32'h13,  32'h0,        32'h000000DE, 0, 1, 1));
        vecs.push_back(mk(1, 2'b01, 0, 32'h12,  32'h8001,     32'h0,        0, 2, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'h80015AEF, 0, 1, 1));
        vecs.push_back(mk(0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFF8001, 0, 1, 1));
        vecs.push_back(mk(0, 2'b01, 1, 32'h12,  32'h0,        32'h00008001, 0, 1, 1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h10,  32'h0,        32'hFFFFFFEF, 0, 1, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h12,  32'h0,        CHK ? 32'h0 : 32'h80015AEF, CHK, 1, 1));
        vecs.push_back(mk(1, 2'b10, 0, 32'h400, 32'h12345678, 32'h0,        1, 1, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0,   32'h0,        32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h401, 32'hAA,       32'h0,        1, 1, 1));
        vecs.push_back(mk(1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 2'b01, 1, 32'h3FE, 32'h0,        32'h0000CAFE, 0, 1, 1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h3FD, 32'h0,        32'hFFFFFFF0, 0, 1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 32'h10,  32'h0,        CHK ? 32'h0 : 32'h80015AEF, CHK, 1, 1));
        vecs.push_back(mk(1, 2'b01, 0, 32'h11,  32'h1234,     32'h0,        CHK, CHK ? 1 : 2, CHK));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        CHK ? 32'h80015AEF : 32'h80011234, 0, 1, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h400, 32'h0,        32'h0,        1, 1, 1));
        word10 = CHK ? 32'h80015AEF : 32'h80011234;

        // Reset held with a pending word store: nothing may happen.
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            check("rst_mem_we",     {31'd0, mem_we},     32'd0);
            check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        end
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        rst_n = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("rst_no_write", dmem[4], 32'd0);
        check("rst_no_resp", {31'd0, resp_valid}, 32'd0);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, rdy_acc, rdy_after);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_ready_acc", i), {31'd0, rdy_acc}, 32'd1);
            check($sformatf("v%0d_ready_after", i), {31'd0, rdy_after}, {31'd0, vecs[i].exp_rdy});
        end
        check("oob_store_no_alias", dmem[0], 32'd0);
        check("word_0x10_model", dmem[4], word10);

        // Back-to-back loads on consecutive cycles.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_addr = 32'h3FC;
        check("b2b_ready", {31'd0, req_ready}, 32'd1);
        check("b2b_valid0", {31'd0, resp_valid}, 32'd1);
        check("b2b_rdata0", resp_rdata, word10);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_valid1", {31'd0, resp_valid}, 32'd1);
        check("b2b_rdata1", resp_rdata, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("b2b_idle", {31'd0, resp_valid}, 32'd0);

        // Reset pulse while the byte store is in its write cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rmw_ready_low", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("rmw_rst_no_resp", seen, 32'd0);
        check("rmw_rst_word", dmem[4], word10);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, rdy_acc, rdy_after);
        check("rmw_rst_load", rd, word10);
        check("rmw_rst_load_lat", lat, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
